// File: rtl/scale_engine_fsm_if.sv
// scale_engine_fsm_if: source RAM read port and framebuffer write port of the scaling engine
interface scale_engine_fsm_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19,
  parameter int PIX_W  = 8
);
  logic [SRC_AW-1:0] src_addr;
  logic [PIX_W-1:0]  src_rdata;
  logic [DST_AW-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_wdata;
  logic              dst_we;
  logic              dst_ready;
  modport master (output src_addr, dst_addr, dst_wdata, dst_we, input src_rdata, dst_ready);
  modport slave  (input src_addr, dst_addr, dst_wdata, dst_we, output src_rdata, dst_ready);
endinterface

// File: rtl/scale_engine_fsm.sv
// scale_engine_fsm: walks the destination frame, resampling the source image by zoom/algorithm into the framebuffer
module scale_engine_fsm #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int DST_W  = 640,
  parameter int DST_H  = 480,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19,
  parameter int PIX_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_pulse_in,
  input  logic [1:0]                algorithm_select_in,
  input  logic [2:0]                zoom_level_in,
  output logic                      processing_done_out,
  output logic                      busy_out,
  scale_engine_fsm_if.master        bus
);
  localparam int CW = 16;
  localparam logic [CW-1:0] SW0 = CW'(SRC_W);
  localparam logic [CW-1:0] SH0 = CW'(SRC_H);
  localparam logic [CW-1:0] XL  = CW'(DST_W - 1);
  localparam logic [CW-1:0] YL  = CW'(DST_H - 1);
  typedef enum logic [2:0] {IDLE, SETUP, READ, ACC, WRITE, ADVANCE, DONE} state_t;
  state_t state, nxt;
  logic zin, avg, acc_en, last, wrap, fin, in0, in_next;
  logic [1:0] k, i, j, fm1, ni, nj;
  logic [2:0] sft;
  logic [CW-1:0] x, y, nx, ny, sw, sh;
  logic [11:0] sum, tot;
  logic [SRC_AW-1:0] src_addr;
  logic [DST_AW-1:0] dst_addr;
  logic [PIX_W-1:0] dst_wdata;

  function automatic logic [SRC_AW-1:0] saddr(input logic [CW-1:0] px, py, input logic [1:0] pi, pj);
    logic [CW-1:0] bx, by;
    bx = (zin ? px >> k : px << k) + CW'(pi);
    by = (zin ? py >> k : py << k) + CW'(pj);
    return SRC_AW'(by) * SRC_AW'(SRC_W) + SRC_AW'(bx);
  endfunction

  assign fm1     = (2'd1 << k) - 2'd1;
  assign last    = !avg || (i == fm1 && j == fm1);
  assign ni      = i == fm1 ? 2'd0 : i + 2'd1;
  assign nj      = i == fm1 ? j + 2'd1 : j;
  assign wrap    = x == XL;
  assign fin     = wrap && y == YL;
  assign nx      = wrap ? '0 : x + CW'(1);
  assign ny      = wrap ? y + CW'(1) : y;
  assign sw      = zin ? SW0 << k : SW0 >> k;
  assign sh      = zin ? SH0 << k : SH0 >> k;
  assign in0     = sw != '0 && sh != '0;
  assign in_next = nx < sw && ny < sh;
  // block average divides by f*f = 2^(2k); single reads pass through unshifted
  assign sft     = avg ? {k, 1'b0} : 3'd0;
  assign tot     = sum + 12'(bus.src_rdata);
  assign bus.src_addr  = src_addr;
  assign bus.dst_addr  = dst_addr;
  assign bus.dst_wdata = dst_wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_pulse_in ? SETUP : IDLE;
      SETUP:   nxt = in0 ? READ : WRITE;
      READ:    nxt = last ? ACC : READ;
      ACC:     nxt = WRITE;
      WRITE:   nxt = bus.dst_ready ? ADVANCE : WRITE;
      ADVANCE: nxt = fin ? DONE : in_next ? READ : WRITE;
      DONE:    nxt = start_pulse_in ? SETUP : DONE;
      default: nxt = IDLE;
    endcase
    processing_done_out = state == DONE;
    busy_out            = state != IDLE && state != DONE;
    bus.dst_we          = state == WRITE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      zin       <= 1'b0;
      avg       <= 1'b0;
      k         <= '0;
      x         <= '0;
      y         <= '0;
      i         <= '0;
      j         <= '0;
      sum       <= '0;
      acc_en    <= 1'b0;
      src_addr  <= '0;
      dst_addr  <= '0;
      dst_wdata <= '0;
    end else case (state)
      IDLE, DONE: if (start_pulse_in) begin
        zin <= zoom_level_in >= 3'd2;
        avg <= zoom_level_in < 3'd2 && algorithm_select_in == 2'b01;
        k   <= (zoom_level_in == 3'd0 || zoom_level_in == 3'd4) ? 2'd2 :
               (zoom_level_in == 3'd1 || zoom_level_in == 3'd3) ? 2'd1 : 2'd0;
        x   <= '0;
        y   <= '0;
      end
      SETUP: begin
        i         <= '0;
        j         <= '0;
        sum       <= '0;
        acc_en    <= 1'b0;
        dst_addr  <= '0;
        dst_wdata <= '0;
        src_addr  <= saddr('0, '0, 2'd0, 2'd0);
      end
      READ: begin
        // data of the previous cycle's address arrives now; the first cycle has none yet
        acc_en <= 1'b1;
        if (acc_en) sum <= tot;
        if (!last) begin
          i        <= ni;
          j        <= nj;
          src_addr <= saddr(x, y, ni, nj);
        end
      end
      ACC: dst_wdata <= PIX_W'(tot >> sft);
      ADVANCE: if (!fin) begin
        x         <= nx;
        y         <= ny;
        dst_addr  <= dst_addr + DST_AW'(1);
        i         <= '0;
        j         <= '0;
        sum       <= '0;
        acc_en    <= 1'b0;
        dst_wdata <= '0;
        if (in_next) src_addr <= saddr(nx, ny, 2'd0, 2'd0);
      end
      default: ;
    endcase
endmodule
